// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
// Contents: md op codes (as decoded by the E-stage controller), default
// latencies, busy-counter width helper, FSM state type and op-class helpers.
package md_pkg;

    // Op encoding driven on the op input alongside start.
    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    // Busy counter must hold the larger latency; one spare bit keeps it safe
    // when the larger latency is an exact power of two.
    function automatic int md_cnt_width(input int mult_cycles, input int div_cycles);
        int max_cycles;
        max_cycles = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return $clog2(max_cycles) + 1;
    endfunction

    localparam int MD_CNT_W = md_cnt_width(MD_MULT_CYCLES, MD_DIV_CYCLES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // Multi-cycle ops (the ones that set busy).
    function automatic logic md_is_long(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Interface between the D/E pipeline register / E-stage datapath and the
// multiply/divide unit.
// Signals: start, op, a, b (into the unit); busy, hi, lo (out of the unit).
// Handshake: start qualifies op/a/b for one cycle and is accepted only when
// busy is low and the unit is idle; busy acts as the inverse of ready, so a
// start presented while busy is high is dropped, never queued.
interface mult_div_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, input  busy, hi, lo);
    modport slave  (input  start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit_calc.sv
// md_calc: purely combinational result generator for the multiply/divide unit.
// Ports:
//   i_op        latched op
//   i_a, i_b    latched operands
//   o_hi, o_lo  result halves (MULT*: product; DIV*: remainder/quotient)
//   o_div_zero  high for a DIV/DIVU whose divisor is zero
module md_calc
    import md_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div_zero
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_signed_div;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide via magnitudes. |0x80000000| stays 0x80000000 as an
    // unsigned value, which makes 0x80000000 / -1 come out as 0x80000000 r 0.
    assign w_signed_div = (i_op == MD_DIV);
    assign w_a_neg      = w_signed_div & i_a[31];
    assign w_b_neg      = w_signed_div & i_b[31];
    assign w_a_mag      = w_a_neg ? (32'd0 - i_a) : i_a;
    assign w_b_mag      = w_b_neg ? (32'd0 - i_b) : i_b;
    // Divisor forced non-zero so the divider never sees /0; the result is discarded then.
    assign w_b_safe     = (i_b == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag      = w_a_mag / w_b_safe;
    assign w_r_mag      = w_a_mag % w_b_safe;
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem        = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    assign o_div_zero   = md_is_div(i_op) && (i_b == 32'd0);

    always_comb begin
        o_hi = 32'd0;
        o_lo = 32'd0;
        case (i_op)
            MD_MULT:  {o_hi, o_lo} = w_prod_s;
            MD_MULTU: {o_hi, o_lo} = w_prod_u;
            MD_DIV, MD_DIVU: begin
                o_hi = w_rem;
                o_lo = w_quot;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk          clock, all state updates on posedge
//   reset        synchronous, active-high; clears all state, aborts in-flight op
//   md           mult_div_unit_if.slave: start/op/a/b in, busy/hi/lo out
//   o_dbg_state  current FSM state
// A mult/div accepted at edge T keeps busy high for exactly N cycles and
// updates HI/LO together on edge T+N, the edge on which busy falls.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    mult_div_unit_if.slave        md,
    output md_state_e             o_dbg_state
);

    localparam int CNT_W = md_cnt_width(MULT_CYCLES, DIV_CYCLES);

    md_state_e        r_state;
    md_state_e        w_state_n;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_n;
    logic             r_busy;
    logic [2:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic             w_latch;
    logic             w_wr_res;
    logic             w_wr_hi;
    logic             w_wr_lo;
    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;
    logic             w_div_zero;

    md_calc u_calc (
        .i_op       (r_op),
        .i_a        (r_a),
        .i_b        (r_b),
        .o_hi       (w_res_hi),
        .o_lo       (w_res_lo),
        .o_div_zero (w_div_zero)
    );

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_latch   = 1'b0;
        w_wr_res  = 1'b0;
        w_wr_hi   = 1'b0;
        w_wr_lo   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (md.start) begin
                    if (md_is_long(md.op)) begin
                        w_latch   = 1'b1;
                        w_state_n = ST_BUSY;
                        w_cnt_n   = md_is_div(md.op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    end else if (md.op == MD_MTHI) begin
                        w_wr_hi = 1'b1;
                    end else if (md.op == MD_MTLO) begin
                        w_wr_lo = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                // start is ignored here; the hazard unit never issues one.
                if (r_cnt == CNT_W'(1)) begin
                    w_state_n = ST_IDLE;
                    w_cnt_n   = '0;
                    // Divide by zero still takes the full latency but leaves HI/LO alone.
                    w_wr_res  = !w_div_zero;
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_op    <= MD_NONE;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_busy  <= (w_state_n == ST_BUSY);
            if (w_latch) begin
                r_op <= md.op;
                r_a  <= md.a;
                r_b  <= md.b;
            end
            if (w_wr_res) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
            if (w_wr_hi) r_hi <= md.a;
            if (w_wr_lo) r_lo <= md.a;
        end
    end

    assign md.busy     = r_busy;
    assign md.hi       = r_hi;
    assign md.lo       = r_lo;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// corner sequences (start during busy, reset mid-divide) and randomized ops
// checked against an arithmetic reference model.
module tb_mult_div_unit;
    import md_pkg::*;

    logic      clk;
    logic      reset;
    md_state_e dbg_state;
    int        n_checks;
    int        n_fail;
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;
    logic [31:0] exp_q[$];

    mult_div_unit_if bus ();

    mult_div_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .md          (bus.slave),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%08h expected=%08h", nm, act, exp);
        end
    endtask

    // Reference model: architectural effect of one accepted op.
    task automatic ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] hi_in, input logic [31:0] lo_in,
                             output logic [31:0] hi_out, output logic [31:0] lo_out,
                             output int cyc);
        longint p;
        longint q;
        longint r;
        longint unsigned pu;
        hi_out = hi_in;
        lo_out = lo_in;
        cyc    = 0;
        case (op)
            MD_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                hi_out = p[63:32]; lo_out = p[31:0]; cyc = 5;
            end
            MD_MULTU: begin
                pu = longint'({32'd0, a}) * longint'({32'd0, b});
                hi_out = pu[63:32]; lo_out = pu[31:0]; cyc = 5;
            end
            MD_DIV: begin
                cyc = 10;
                if (b != 0) begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    hi_out = r[31:0]; lo_out = q[31:0];
                end
            end
            MD_DIVU: begin
                cyc = 10;
                if (b != 0) begin
                    hi_out = a % b; lo_out = a / b;
                end
            end
            MD_MTHI: hi_out = a;
            MD_MTLO: lo_out = a;
            default: ;
        endcase
    endtask

    // ---------------- driver ----------------
    // Called at a negedge with the unit idle. Issues one op, checks busy and
    // held HI/LO for n cycles, then the result. Live a/b are scrambled after
    // the start cycle; inj_at >= 0 presents an extra start on that busy cycle.
    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int inj_at, input logic [2:0] inj_op, input logic [31:0] inj_a);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        for (int i = 0; i < n; i++) begin
            chk({nm, ".busy"}, {31'd0, bus.busy}, 32'd1);
            chk({nm, ".hold_hi"}, bus.hi, cur_hi);
            chk({nm, ".hold_lo"}, bus.lo, cur_lo);
            chk({nm, ".state"}, 32'(dbg_state), 32'(ST_BUSY));
            if (i == inj_at) begin
                bus.start = 1'b1;
                bus.op    = inj_op;
                bus.a     = inj_a;
            end else begin
                bus.start = 1'b0;
                bus.op    = 3'($urandom_range(0, 7));
                bus.a     = $urandom;
                bus.b     = $urandom;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        exp_q.push_back(ehi);
        exp_q.push_back(elo);
        chk({nm, ".busy_end"}, {31'd0, bus.busy}, 32'd0);
        chk({nm, ".hi"}, bus.hi, exp_q.pop_front());
        chk({nm, ".lo"}, bus.lo, exp_q.pop_front());
        chk({nm, ".state_end"}, 32'(dbg_state), 32'(ST_IDLE));
        cur_hi = ehi;
        cur_lo = elo;
    endtask

    typedef struct {
        string       nm;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        int          cyc;
        int          inj;

        n_checks = 0;
        n_fail   = 0;
        cur_hi   = 32'd0;
        cur_lo   = 32'd0;

        vecs[0]  = '{"mult_3xm2",     MD_MULT,  32'h3,        32'hFFFFFFFE, 5,  32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{"multu_max_x2",  MD_MULTU, 32'hFFFFFFFF, 32'h2,        5,  32'h1,        32'hFFFFFFFE};
        vecs[2]  = '{"div_m7_2",      MD_DIV,   32'hFFFFFFF9, 32'h2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"mthi",          MD_MTHI,  32'h1234,     32'h0,        0,  32'h1234,     32'hFFFFFFFD};
        vecs[4]  = '{"mtlo",          MD_MTLO,  32'h5678,     32'h0,        0,  32'h1234,     32'h5678};
        vecs[5]  = '{"divu_by0",      MD_DIVU,  32'h5,        32'h0,        10, 32'h1234,     32'h5678};
        vecs[6]  = '{"div_ovf",       MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h0,        32'h80000000};
        vecs[7]  = '{"op_none",       MD_NONE,  32'h99,       32'h1,        0,  32'h0,        32'h80000000};
        vecs[8]  = '{"op_7",          3'd7,     32'h99,       32'h1,        0,  32'h0,        32'h80000000};
        vecs[9]  = '{"divu_100_7",    MD_DIVU,  32'd100,      32'd7,        10, 32'd2,        32'd14};
        vecs[10] = '{"div_7_m2",      MD_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h1,        32'hFFFFFFFD};
        vecs[11] = '{"div_by0",       MD_DIV,   32'h5,        32'h0,        10, 32'h1,        32'hFFFFFFFD};
        vecs[12] = '{"mult_min_sq",   MD_MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h0};

        // ---------------- reset ----------------
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = MD_NONE;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset.busy", {31'd0, bus.busy}, 32'd0);
        chk("reset.hi", bus.hi, 32'd0);
        chk("reset.lo", bus.lo, 32'd0);
        chk("reset.state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b0;

        // ---------------- directed table ----------------
        for (int i = 0; i < 13; i++)
            run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cyc,
                   vecs[i].hi, vecs[i].lo, -1, MD_NONE, 32'd0);

        // ---------------- MTHI during busy is ignored ----------------
        run_op("mult_inj_mthi", MD_MULT, 32'h10, 32'h20, 5, 32'h0, 32'h200, 1, MD_MTHI, 32'hAAAA);
        run_op("div_inj_mult", MD_DIV, 32'd50, 32'd6, 10, 32'd2, 32'd8, 7, MD_MULT, 32'h7);

        // ---------------- randomized vs reference model ----------------
        for (int k = 0; k < 60; k++) begin
            r_op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: begin r_a = 32'h80000000; r_b = 32'hFFFFFFFF; end
                1: begin r_a = $urandom; r_b = 32'd0; end
                2: begin r_a = $urandom_range(0, 20); r_b = $urandom_range(1, 5); end
                default: begin r_a = $urandom; r_b = $urandom; end
            endcase
            ref_model(r_op, r_a, r_b, cur_hi, cur_lo, e_hi, e_lo, cyc);
            inj = (cyc > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, cyc - 1)) : -1;
            run_op($sformatf("rand%0d", k), r_op, r_a, r_b, cyc, e_hi, e_lo,
                   inj, 3'($urandom_range(1, 6)), $urandom);
        end

        // Make HI/LO non-zero so the reset clear below is observable.
        run_op("pre_reset_mtlo", MD_MTLO, 32'hCAFE0001, 32'd0, 0, cur_hi, 32'hCAFE0001, -1, MD_NONE, 32'd0);

        // ---------------- reset on busy cycle 4 of a DIV ----------------
        bus.start = 1'b1;
        bus.op    = MD_DIV;
        bus.a     = 32'd100;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rst_div.busy", {31'd0, bus.busy}, 32'd1);
            if (i == 3) reset = 1'b1;
            @(negedge clk);
        end
        reset = 1'b0;
        chk("rst_div.busy_after", {31'd0, bus.busy}, 32'd0);
        chk("rst_div.hi", bus.hi, 32'd0);
        chk("rst_div.lo", bus.lo, 32'd0);
        chk("rst_div.state", 32'(dbg_state), 32'(ST_IDLE));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("rst_div.no_late_busy", {31'd0, bus.busy}, 32'd0);
            chk("rst_div.no_late_hi", bus.hi, 32'd0);
            chk("rst_div.no_late_lo", bus.lo, 32'd0);
        end
        cur_hi = 32'd0;
        cur_lo = 32'd0;

        // Unit is usable again after the abort.
        run_op("post_reset_multu", MD_MULTU, 32'd7, 32'd6, 5, 32'd0, 32'd42, -1, MD_NONE, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
